// File: rtl/count_down_timer_pkg.sv
// Shared types and defaults for the loadable down-counter/timer.
package count_down_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/count_down_timer_tick_div.sv
// Prescaler: emits one tick every PRESCALE enabled cycles.
module count_tick_div #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_direct
            logic unused_ok;
            assign unused_ok = ^{clk, rst, clr};
            assign tick      = run;
        end else begin : g_div
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pre;

            assign tick = run && (pre == LAST);

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    pre <= '0;
                end else if (run) begin
                    pre <= tick ? '0 : pre + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/count_down_timer.sv
// Loadable down-counter: counts load_val to zero at the prescaled rate,
// pulses done, optionally reloads for a periodic interval.
module count_down_timer
    import count_down_timer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             done_nxt;
    logic             run;
    logic             tick;
    logic             terminal;

    // load and stop outrank a tick, so the prescaler must not advance then
    assign run      = (state == ST_RUN) && en && !stop && !load;
    assign terminal = (cnt == ONE);

    count_tick_div #(
        .PRESCALE (PRESCALE)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .run  (run),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = (load_val != '0) ? ST_RUN : ST_IDLE;
        end else if (stop) begin
            state_nxt = ST_IDLE;
        end else if (tick && terminal && !auto_reload) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        cnt_nxt    = cnt;
        reload_nxt = reload_reg;
        done_nxt   = 1'b0;
        if (load) begin
            reload_nxt = load_val;
            cnt_nxt    = load_val;
            done_nxt   = (load_val == '0);
        end else if (stop) begin
            cnt_nxt = cnt;
        end else if (tick) begin
            if (terminal) begin
                done_nxt = 1'b1;
                cnt_nxt  = auto_reload ? reload_reg : '0;
            end else if (cnt != '0) begin
                cnt_nxt = cnt - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            reload_reg <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            reload_reg <= reload_nxt;
            done       <= done_nxt;
            busy       <= (state_nxt == ST_RUN);
        end
    end

endmodule

// File: tb/tb_count_down_timer.sv
// Scoreboard bench for count_down_timer at PRESCALE=1 and PRESCALE=4.
module tb_count_down_timer;

    typedef struct packed {
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic [7:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_load = 0, a_en = 0, a_stop = 0, a_ar = 0;
    logic [7:0] a_val = 0;
    logic [7:0] a_cnt;
    logic       a_busy, a_done;

    logic       b_load = 0, b_en = 0, b_stop = 0, b_ar = 0;
    logic [7:0] b_val = 0;
    logic [7:0] b_cnt;
    logic       b_busy, b_done;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    count_down_timer #(.WIDTH(8), .PRESCALE(1)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .load        (a_load),
        .load_val    (a_val),
        .en          (a_en),
        .stop        (a_stop),
        .auto_reload (a_ar),
        .cnt         (a_cnt),
        .busy        (a_busy),
        .done        (a_done)
    );

    count_down_timer #(.WIDTH(8), .PRESCALE(4)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .load        (b_load),
        .load_val    (b_val),
        .en          (b_en),
        .stop        (b_stop),
        .auto_reload (b_ar),
        .cnt         (b_cnt),
        .busy        (b_busy),
        .done        (b_done)
    );

    task automatic step_rst(input logic [7:0] tg);
        @(negedge clk);
        rst    = 1'b1;
        a_load = 0; a_stop = 0; a_en = 0; a_ar = 0;
        b_load = 0; b_stop = 0; b_en = 0; b_ar = 0;
        qa.push_back('{cnt: 8'd0, busy: 1'b0, done: 1'b0, tag: tg});
        qb.push_back('{cnt: 8'd0, busy: 1'b0, done: 1'b0, tag: tg});
    endtask

    task automatic stepa(input logic ld, input logic [7:0] v,
                         input logic e, input logic sp, input logic ar,
                         input logic [7:0] ec, input logic eb,
                         input logic ed, input logic [7:0] tg);
        @(negedge clk);
        rst = 1'b0;
        a_load = ld; a_val = v; a_en = e; a_stop = sp; a_ar = ar;
        qa.push_back('{cnt: ec, busy: eb, done: ed, tag: tg});
    endtask

    task automatic stepb(input logic ld, input logic [7:0] v,
                         input logic e, input logic [7:0] ec,
                         input logic eb, input logic ed,
                         input logic [7:0] tg);
        @(negedge clk);
        rst = 1'b0;
        b_load = ld; b_val = v; b_en = e; b_stop = 0; b_ar = 0;
        qb.push_back('{cnt: ec, busy: eb, done: ed, tag: tg});
    endtask

    initial begin : mon_a
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() != 0) begin
                e = qa.pop_front();
                checks++;
                if ({a_cnt, a_busy, a_done} !== {e.cnt, e.busy, e.done}) begin
                    errors++;
                    $display("FAIL a_t%0d: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
                             e.tag, a_cnt, a_busy, a_done, e.cnt, e.busy, e.done);
                end
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qb.size() != 0) begin
                e = qb.pop_front();
                checks++;
                if ({b_cnt, b_busy, b_done} !== {e.cnt, e.busy, e.done}) begin
                    errors++;
                    $display("FAIL b_t%0d: got cnt=%0d busy=%b done=%b, want cnt=%0d busy=%b done=%b",
                             e.tag, b_cnt, b_busy, b_done, e.cnt, e.busy, e.done);
                end
            end
        end
    end

    initial begin : stim
        step_rst(0);
        step_rst(0);

        // 1: load 5, plain countdown
        stepa(1, 5, 1, 0, 0, 5, 1, 0, 1);
        for (int i = 4; i >= 1; i--) stepa(0, 0, 1, 0, 0, 8'(i), 1, 0, 1);
        stepa(0, 0, 1, 0, 0, 0, 0, 1, 1);
        stepa(0, 0, 1, 0, 0, 0, 0, 0, 1);

        // 2: auto-reload period 3, then let it lapse
        stepa(1, 3, 1, 0, 1, 3, 1, 0, 2);
        for (int r = 0; r < 2; r++) begin
            stepa(0, 0, 1, 0, 1, 2, 1, 0, 2);
            stepa(0, 0, 1, 0, 1, 1, 1, 0, 2);
            stepa(0, 0, 1, 0, 1, 3, 1, 1, 2);
        end
        stepa(0, 0, 1, 0, 0, 2, 1, 0, 2);
        stepa(0, 0, 1, 0, 0, 1, 1, 0, 2);
        stepa(0, 0, 1, 0, 0, 0, 0, 1, 2);
        stepa(0, 0, 1, 0, 0, 0, 0, 0, 2);

        // 4: load 0 and load 255
        stepa(1, 0, 1, 0, 0, 0, 0, 1, 4);
        stepa(0, 0, 1, 0, 0, 0, 0, 0, 4);
        stepa(1, 255, 1, 0, 0, 255, 1, 0, 5);
        for (int i = 254; i >= 1; i--) stepa(0, 0, 1, 0, 0, 8'(i), 1, 0, 5);
        stepa(0, 0, 1, 0, 0, 0, 0, 1, 5);
        stepa(0, 0, 1, 0, 0, 0, 0, 0, 5);

        // 5: stop at 7, stop in idle, load+stop, pause
        stepa(1, 10, 1, 0, 0, 10, 1, 0, 6);
        for (int i = 9; i >= 7; i--) stepa(0, 0, 1, 0, 0, 8'(i), 1, 0, 6);
        stepa(0, 0, 1, 1, 0, 7, 0, 0, 6);
        stepa(0, 0, 1, 0, 0, 7, 0, 0, 6);
        stepa(0, 0, 1, 1, 0, 7, 0, 0, 6);
        stepa(1, 4, 1, 1, 0, 4, 1, 0, 7);
        stepa(0, 0, 0, 0, 0, 4, 1, 0, 7);
        stepa(0, 0, 0, 0, 0, 4, 1, 0, 7);
        for (int i = 3; i >= 1; i--) stepa(0, 0, 1, 0, 0, 8'(i), 1, 0, 7);
        stepa(0, 0, 1, 0, 0, 0, 0, 1, 7);

        // 6: reset mid-run
        stepa(1, 12, 1, 0, 0, 12, 1, 0, 8);
        for (int i = 11; i >= 9; i--) stepa(0, 0, 1, 0, 0, 8'(i), 1, 0, 8);
        step_rst(8);
        for (int i = 0; i < 12; i++) stepa(0, 0, 1, 0, 0, 0, 0, 0, 8);

        // 3: PRESCALE=4, load 2 -> done after 8
        stepb(1, 2, 1, 2, 1, 0, 3);
        for (int k = 1; k <= 8; k++)
            stepb(0, 0, 1, (k < 4) ? 8'd2 : (k < 8) ? 8'd1 : 8'd0,
                  k < 8, k == 8, 3);
        // en low for 3 cycles -> done after 11
        stepb(1, 2, 1, 2, 1, 0, 9);
        for (int k = 1; k <= 11; k++)
            stepb(0, 0, (k < 3 || k > 5),
                  (k < 7) ? 8'd2 : (k < 11) ? 8'd1 : 8'd0,
                  k < 11, k == 11, 9);
        stepb(0, 0, 1, 0, 0, 0, 9);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
